resta1_pipe: RTL and testbench

- Registered decrement-by-one unit; the subtract counterpart of the ALU's +1 unit.
- Selects operand a or b via aluflagin, computes operand-1 and N/Z/C/V flags.
- Two-stage pipeline with valid/ready handshake on both sides, so the ALU sequencer can stream operations and tolerate back-pressure from the result writeback.

---
 rtl/resta1_pipe.sv | 107 ++++++++++
 tb/tb_resta1_pipe.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resta1_pipe.sv
// resta1_pipe: two-stage registered decrement-by-one unit.
// Stage 1 latches the selected operand. Stage 2 holds the result (operand - 1)
// and its N/Z/C/V flags. Both sides use a valid/ready handshake, and the only
// combinational paths are out_ready -> in_ready and rst -> in_ready.
module resta1_pipe #(
    parameter int ancho = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ancho-1:0] a,
    input  logic [ancho-1:0] b,
    input  logic             aluflagin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ancho-1:0] aluresult,
    output logic [3:0]       aluflags,
    output logic             out_valid,
    input  logic             out_ready
);

    // Decrement constant and the most negative signed value; decrementing
    // that value is the only case that underflows in two's complement.
    localparam logic [ancho-1:0] ONE     = ancho'(1);
    localparam logic [ancho-1:0] MIN_NEG = {1'b1, {(ancho-1){1'b0}}};

    logic [ancho-1:0] opnd_q, opnd_d;
    logic             s1Valid_q, s1Valid_d;
    logic [ancho-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             outValid_q, outValid_d;

    logic             s2Take;
    logic             s1Advance;
    logic             inXfer;
    logic [ancho-1:0] diff;
    logic [3:0]       diffFlags;

    // Handshake glue: S2 can accept when it is empty or is being drained this
    // cycle, and S1 can accept when it is empty or is moving into S2.
    always_comb begin
        s2Take    = !outValid_q || out_ready;
        s1Advance = s1Valid_q && s2Take;
        in_ready  = !rst && (!s1Valid_q || s2Take);
        inXfer    = in_valid && in_ready;
    end

    // Decrement and flag generation, all derived from the operand held in S1.
    always_comb begin
        diff      = opnd_q - ONE;
        diffFlags = {diff[ancho-1],
                     (opnd_q == ONE),
                     (opnd_q == '0),
                     (opnd_q == MIN_NEG)};
    end

    // Stage 1 next state: a new operand wins; otherwise the slot empties once
    // its operand moves to S2, and holds during a stall.
    always_comb begin
        opnd_d    = opnd_q;
        s1Valid_d = s1Valid_q;
        if (inXfer) begin
            opnd_d    = aluflagin ? b : a;
            s1Valid_d = 1'b1;
        end else if (s1Advance) begin
            s1Valid_d = 1'b0;
        end
    end

    // Stage 2 next state: whenever S2 may take, it reloads its valid bit from
    // S1. Data only updates for a real operation, so a bubble keeps the last
    // result and flags on the outputs.
    always_comb begin
        result_d   = result_q;
        flags_d    = flags_q;
        outValid_d = outValid_q;
        if (s2Take) begin
            outValid_d = s1Valid_q;
            if (s1Valid_q) begin
                result_d = diff;
                flags_d  = diffFlags;
            end
        end
    end

    // Pipeline registers. A synchronous reset flushes both stages, even
    // while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            opnd_q     <= '0;
            s1Valid_q  <= 1'b0;
            result_q   <= '0;
            flags_q    <= 4'b0000;
            outValid_q <= 1'b0;
        end else begin
            opnd_q     <= opnd_d;
            s1Valid_q  <= s1Valid_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            outValid_q <= outValid_d;
        end
    end

    assign aluresult = result_q;
    assign aluflags  = flags_q;
    assign out_valid = outValid_q;

endmodule

// File: tb/tb_resta1_pipe.sv
// tb_resta1_pipe: self-checking bench for resta1_pipe with ancho = 4.
// A scoreboard queue holds the expected results, which are computed with
// plain integer arithmetic when each input transfer is observed. Every
// output transfer is compared with the head of the queue.
module tb_resta1_pipe;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       aluflagin;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] aluresult;
    logic [3:0] aluflags;
    logic       out_valid;
    logic       out_ready;

    typedef struct {
        logic [3:0] r;
        logic [3:0] f;
        int         cyc;
    } exp_t;

    exp_t       expQ[$];
    int         checks;
    int         errors;
    int         cycleCount;
    logic       checkLatency;
    logic       lastInX;
    logic       lastOutX;
    logic       prevStall;
    logic [3:0] prevRes;
    logic [3:0] prevFlags;
    int         outCount;

    resta1_pipe #(.ancho(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .aluflagin (aluflagin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluresult (aluresult),
        .aluflags  (aluflags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: decrement the operand as an integer, then derive the
    // flags from the integer and signed interpretations of that value.
    function automatic void model(input int opnd, output logic [3:0] r, output logic [3:0] f);
        int diff;
        int sv;
        diff = opnd - 1;
        r    = 4'((diff + 16) % 16);
        sv   = (opnd >= 8) ? opnd - 16 : opnd;
        f[3] = (r >= 4'd8);
        f[2] = (r == 4'd0);
        f[1] = (diff < 0);
        f[0] = ((sv - 1) < -8);
    endfunction

    // One clock cycle. It samples the handshakes mid-cycle, updates the
    // scoreboard, checks that a stalled output held its value, and then
    // moves just past the next rising edge.
    task automatic stepCycle;
        logic       inX;
        logic       outX;
        logic       wasReset;
        logic [3:0] er;
        logic [3:0] ef;
        exp_t       e;
        #1;
        if (prevStall === 1'b1) begin
            checks++;
            if (out_valid !== 1'b1 || aluresult !== prevRes || aluflags !== prevFlags) begin
                errors++;
                $display("[TB] FAIL stall_hold: got v=%b r=%0d f=%b, expected v=1 r=%0d f=%b",
                         out_valid, aluresult, aluflags, prevRes, prevFlags);
            end
        end
        inX  = (in_valid === 1'b1) && (in_ready === 1'b1);
        outX = (out_valid === 1'b1) && (out_ready === 1'b1);
        if (outX) begin
            checks++;
            outCount++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_output: got r=%0d f=%b, expected no output",
                         aluresult, aluflags);
            end else begin
                e = expQ.pop_front();
                if (aluresult !== e.r || aluflags !== e.f) begin
                    errors++;
                    $display("[TB] FAIL result: got r=%0d f=%b, expected r=%0d f=%b",
                             aluresult, aluflags, e.r, e.f);
                end
                if (checkLatency) begin
                    checks++;
                    if (cycleCount - e.cyc != 2) begin
                        errors++;
                        $display("[TB] FAIL latency: got %0d cycles, expected 2",
                                 cycleCount - e.cyc);
                    end
                end
            end
        end
        if (inX) begin
            model(int'(aluflagin ? b : a), er, ef);
            e.r   = er;
            e.f   = ef;
            e.cyc = cycleCount;
            expQ.push_back(e);
        end
        lastInX   = inX;
        lastOutX  = outX;
        prevStall = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst === 1'b0);
        prevRes   = aluresult;
        prevFlags = aluflags;
        wasReset  = rst;
        @(posedge clk);
        #1;
        cycleCount++;
        if (wasReset === 1'b1) begin
            expQ.delete();
            prevStall = 1'b0;
        end
    endtask

    // Runs until every expected result has left the unit; a timeout counts
    // as a failure.
    task automatic drain;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (expQ.size() == 0 && out_valid !== 1'b1) break;
            stepCycle();
        end
        checks++;
        if (expQ.size() != 0 || out_valid === 1'b1) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 4'd0;
        b         = 4'd0;
        aluflagin = 1'b0;
        stepCycle();
        stepCycle();
        checks++;
        if (out_valid !== 1'b0 || aluresult !== 4'd0 || aluflags !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_state: got v=%b r=%0d f=%b, expected v=0 r=0 f=0000",
                     out_valid, aluresult, aluflags);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_reset_during_op;
        int waitCnt;
        out_ready = 1'b0;
        a         = 4'd7;
        aluflagin = 1'b0;
        in_valid  = 1'b1;
        stepCycle();
        in_valid = 1'b0;
        waitCnt  = 0;
        while (out_valid !== 1'b1 && waitCnt < 10) begin
            stepCycle();
            waitCnt++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL op_loaded: got v=%b, expected 1", out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL in_ready_during_rst: got %b, expected 0", in_ready);
        end
        stepCycle();
        checks++;
        if (out_valid !== 1'b0 || aluresult !== 4'd0 || aluflags !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midstall_reset: got v=%b r=%0d f=%b, expected v=0 r=0 f=0000",
                     out_valid, aluresult, aluflags);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL in_ready_after_rst: got %b, expected 1", in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) stepCycle();
    endtask

    task automatic test_basic_select;
        outCount     = 0;
        checkLatency = 1'b1;
        out_ready    = 1'b1;
        a            = 4'd5;
        b            = 4'd9;
        aluflagin    = 1'b0;
        in_valid     = 1'b1;
        stepCycle();
        aluflagin = 1'b1;
        stepCycle();
        drain();
        checkLatency = 1'b0;
        checks++;
        if (outCount != 2) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d outputs, expected 2", outCount);
        end
    endtask

    task automatic test_boundaries;
        int vals[4];
        vals         = '{0, 1, 8, 15};
        outCount     = 0;
        checkLatency = 1'b1;
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            aluflagin = i[0];
            a         = i[0] ? 4'd3 : 4'(vals[i]);
            b         = i[0] ? 4'(vals[i]) : 4'd12;
            stepCycle();
        end
        drain();
        checkLatency = 1'b0;
        checks++;
        if (outCount != 4) begin
            errors++;
            $display("[TB] FAIL boundary_count: got %0d outputs, expected 4", outCount);
        end
    endtask

    task automatic test_back_pressure;
        int ops[4];
        int idx;
        ops       = '{3, 4, 5, 6};
        idx       = 0;
        outCount  = 0;
        out_ready = 1'b0;
        aluflagin = 1'b0;
        a         = 4'(ops[0]);
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            if (lastInX) idx++;
            if (idx < 4) a = 4'(ops[idx]);
            else in_valid = 1'b0;
        end
        #1;
        checks++;
        if (out_valid !== 1'b1 || aluresult !== 4'd2) begin
            errors++;
            $display("[TB] FAIL bp_stall_out: got v=%b r=%0d, expected v=1 r=2", out_valid, aluresult);
        end
        checks++;
        if (in_ready !== 1'b0 || idx != 2) begin
            errors++;
            $display("[TB] FAIL bp_full: got in_ready=%b accepted=%0d, expected in_ready=0 accepted=2",
                     in_ready, idx);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && idx < 4; i++) begin
            stepCycle();
            if (lastInX) idx++;
            if (idx < 4) a = 4'(ops[idx]);
            else in_valid = 1'b0;
        end
        drain();
        checks++;
        if (outCount != 4) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d outputs, expected 4", outCount);
        end
    endtask

    task automatic test_random;
        int accepted;
        accepted = 0;
        outCount = 0;
        for (int i = 0; i < 5000 && accepted < 200; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            a         = 4'($urandom_range(0, 15));
            b         = 4'($urandom_range(0, 15));
            aluflagin = 1'($urandom_range(0, 1));
            stepCycle();
            if (lastInX) accepted++;
        end
        drain();
        checks++;
        if (accepted != 200 || outCount != 200) begin
            errors++;
            $display("[TB] FAIL random_count: got in=%0d out=%0d, expected 200/200",
                     accepted, outCount);
        end
    endtask

    // Runs the scenarios in order and prints the summary.
    initial begin
        checks       = 0;
        errors       = 0;
        cycleCount   = 0;
        checkLatency = 1'b0;
        prevStall    = 1'b0;
        prevRes      = 4'd0;
        prevFlags    = 4'd0;
        outCount     = 0;
        lastInX      = 1'b0;
        lastOutX     = 1'b0;
        test_reset();
        test_reset_during_op();
        test_basic_select();
        test_boundaries();
        test_back_pressure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
